spike_rate_decoder: RTL

Receive-side decoder for the LIF neuron's spike train: converts the 1-bit spike output back into numeric values. Per programmable window it counts spike cycles and reports an 8-bit firing rate through a valid/ready handshake. Continuously, it reports the inter-spike interval (ISI) between consecutive spikes. It sits directly downstream of the neuron's `spike` output inside the Tiny Tapeout top level, closing the current→spike→value loop for readout and self-test.

---
 rtl/spike_rate_decoder_if.sv | 16 +
 rtl/spike_rate_decoder.sv | 58 +++++
 2 files changed

// File: rtl/spike_rate_decoder_if.sv
// spike_rate_decoder_if: spike input, window control and rate/ISI result bus
interface spike_rate_decoder_if #(parameter int CNT_W = 8);
  logic             en;
  logic             spike;
  logic [CNT_W-1:0] window_len;
  logic [CNT_W-1:0] rate;
  logic             rate_valid;
  logic             rate_ready;
  logic             overrun;
  logic [CNT_W-1:0] isi;
  logic             isi_valid;
  modport master (output en, spike, window_len, rate_ready,
                  input rate, rate_valid, overrun, isi, isi_valid);
  modport slave (input en, spike, window_len, rate_ready,
                 output rate, rate_valid, overrun, isi, isi_valid);
endinterface

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: windowed firing-rate count and inter-spike interval from a 1-bit spike train
module spike_rate_decoder #(parameter int CNT_W = 8) (
  input logic clk,
  input logic rst,
  spike_rate_decoder_if.slave io_bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state;
  logic [CNT_W-1:0] r_len, r_wcnt, r_scnt, r_icnt, r_rate, r_isi;
  logic r_have, r_rate_valid, r_overrun, r_isi_valid;
  logic w_run, w_last, w_load, w_isi;
  logic [CNT_W-1:0] w_len, w_wcnt, w_scnt, w_final, w_icnt_inc;
  // the IDLE->RUN cycle is window cycle 0, so it sees zeroed counters and the live window_len
  always_comb begin
    w_run = r_state == RUN;
    w_len = w_run ? r_len : io_bus.window_len;
    w_wcnt = w_run ? r_wcnt : '0;
    w_scnt = w_run ? r_scnt : '0;
    w_last = w_wcnt == w_len - CNT_W'(1);
    w_final = &w_scnt ? w_scnt : w_scnt + CNT_W'(io_bus.spike);
    w_load = io_bus.en && w_last;
    w_isi = io_bus.en && io_bus.spike && r_have;
    w_icnt_inc = &r_icnt ? r_icnt : r_icnt + CNT_W'(1);
  end
  // window/ISI counters, FSM and registered result handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_len <= '0;
      r_wcnt <= '0;
      r_scnt <= '0;
      r_icnt <= '0;
      r_have <= 1'b0;
      r_rate <= '0;
      r_rate_valid <= 1'b0;
      r_overrun <= 1'b0;
      r_isi <= '0;
      r_isi_valid <= 1'b0;
    end else begin
      r_state <= io_bus.en ? RUN : IDLE;
      r_len <= (io_bus.en && (w_last || !w_run)) ? io_bus.window_len : r_len;
      r_wcnt <= (io_bus.en && !w_last) ? w_wcnt + CNT_W'(1) : '0;
      r_scnt <= (io_bus.en && !w_last) ? w_final : '0;
      r_icnt <= (io_bus.en && !io_bus.spike) ? w_icnt_inc : '0;
      r_have <= io_bus.en && (r_have || io_bus.spike);
      r_rate <= w_load ? w_final : r_rate;
      r_rate_valid <= w_load || (r_rate_valid && !io_bus.rate_ready);
      r_overrun <= r_overrun || (w_load && r_rate_valid && !io_bus.rate_ready);
      r_isi <= w_isi ? w_icnt_inc : r_isi;
      r_isi_valid <= w_isi;
    end
  end
  assign io_bus.rate = r_rate;
  assign io_bus.rate_valid = r_rate_valid;
  assign io_bus.overrun = r_overrun;
  assign io_bus.isi = r_isi;
  assign io_bus.isi_valid = r_isi_valid;
endmodule
